// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
//   arb_state_t : arbiter FSM states (IDLE, SEND, GAP)
//   ARB_RR      : round-robin arbitration mode
//   ARB_FIXED   : fixed-priority arbitration mode (lowest index wins)
//   IFG_MAX     : largest supported inter-frame gap, in cycles
package eth_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  localparam int IFG_MAX   = 15;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice. The outputs come straight from flops, and
// the upstream ready comes straight from a flop. It sustains one beat per cycle
// while the downstream ready stays high.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   s_valid_i/s_ready_o  upstream handshake
//   s_data_i/s_keep_i/s_last_i  upstream payload
//   m_valid_o/m_ready_i  downstream handshake
//   m_data_o/m_keep_o/m_last_o  downstream payload (held while stalled)
//   empty_o              no beat held in either entry
module axis_skid_buffer #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [KEEP_W-1:0] s_keep_i,
  input  logic              s_last_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [KEEP_W-1:0] m_keep_o,
  output logic              m_last_o,
  output logic              empty_o
);

  logic              out_vld_q;
  logic [DATA_W-1:0] out_data_q;
  logic [KEEP_W-1:0] out_keep_q;
  logic              out_last_q;
  logic              skid_vld_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [KEEP_W-1:0] skid_keep_q;
  logic              skid_last_q;

  // The upstream is accepted whenever the spare entry is free. A beat that
  // arrives while the output is stalled is parked in the spare entry.
  assign s_ready_o = ~skid_vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_keep_q <= '0;
      skid_last_q <= 1'b0;
    end else if (!out_vld_q || m_ready_i) begin
      if (skid_vld_q) begin
        out_vld_q  <= 1'b1;
        out_data_q <= skid_data_q;
        out_keep_q <= skid_keep_q;
        out_last_q <= skid_last_q;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= s_valid_i;
        if (s_valid_i) begin
          out_data_q <= s_data_i;
          out_keep_q <= s_keep_i;
          out_last_q <= s_last_i;
        end
      end
    end else if (s_valid_i && !skid_vld_q) begin
      skid_vld_q  <= 1'b1;
      skid_data_q <= s_data_i;
      skid_keep_q <= s_keep_i;
      skid_last_q <= s_last_i;
    end
  end

  assign m_valid_o = out_vld_q;
  assign m_data_o  = out_data_q;
  assign m_keep_o  = out_keep_q;
  assign m_last_o  = out_last_q;
  assign empty_o   = ~out_vld_q & ~skid_vld_q;

endmodule

// File: rtl/ethernet_tx_frame_arbiter.sv
// N:1 frame-atomic AXI-Stream arbiter. It merges the per-protocol reply streams
// (ARP, ICMP, UDP, ...) onto the single MAC TX port.
// Ports:
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   s_axis_*               NUM_CH input streams; channel i sits at slice i
//   m_axis_*               merged output stream through a 2-entry skid buffer
//   o_grant                one-hot owner of the current frame, 0 when idle
//   o_busy                 arbiter not in IDLE
//   o_frame_cnt            per-channel count of frames completed on m_axis (wraps)
module ethernet_tx_frame_arbiter
  import eth_tx_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 64,
  parameter int ARB_MODE = ARB_RR,
  parameter int IFG_CYC  = 1,
  parameter int CNT_W    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_CH-1:0]             s_axis_tvalid,
  output logic [NUM_CH-1:0]             s_axis_tready,
  input  logic [NUM_CH*DATA_W-1:0]      s_axis_tdata,
  input  logic [NUM_CH*(DATA_W/8)-1:0]  s_axis_tkeep,
  input  logic [NUM_CH-1:0]             s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic [(DATA_W/8)-1:0]         m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [NUM_CH-1:0]             o_grant,
  output logic                          o_busy,
  output logic [NUM_CH*CNT_W-1:0]       o_frame_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t        state_q;
  logic [NUM_CH-1:0] grant_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [3:0]        gap_cnt_q;
  logic              tlast_out_q;   // frame's tlast has left m_axis; counting the gap
  logic [CNT_W-1:0]  cnt_q [NUM_CH];

  // Arbitration: scan the requests starting at the pointer. Fixed-priority mode
  // pins the pointer to 0, so the lowest index always wins.
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] win_next;
  logic             win_found;

  always_comb begin
    start_idx = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_idx = IDX_W'((int'(start_idx) + k) % NUM_CH);
      if (!win_found && s_axis_tvalid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_next = (int'(win_idx) == NUM_CH - 1) ? '0 : win_idx + 1'b1;
  end

  // Granted-channel mux feeding the skid buffer.
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_last;
  logic              sel_valid;
  logic              skid_ready;
  logic              skid_empty;
  logic              s_accept;
  logic              m_hs_last;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) begin
        sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
        sel_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        sel_last  = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
    // In GAP the grant is still held for counting, but no new beats may enter.
    if (state_q != SEND) sel_valid = 1'b0;
  end

  assign s_accept      = sel_valid & skid_ready;
  assign s_axis_tready = (state_q == SEND) ? (grant_q & {NUM_CH{skid_ready}}) : '0;
  assign m_hs_last     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  axis_skid_buffer #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_skid (
    .clk_i     (i_clk),
    .rst_ni    (i_reset_n),
    .s_valid_i (sel_valid),
    .s_ready_o (skid_ready),
    .s_data_i  (sel_data),
    .s_keep_i  (sel_keep),
    .s_last_i  (sel_last),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready),
    .m_data_o  (m_axis_tdata),
    .m_keep_o  (m_axis_tkeep),
    .m_last_o  (m_axis_tlast),
    .empty_o   (skid_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      tlast_out_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_hs_last && grant_q[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q     <= SEND;
            grant_q     <= {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
            tlast_out_q <= 1'b0;
            if (ARB_MODE == ARB_RR) rr_ptr_q <= win_next;
          end
        end
        SEND: begin
          if (s_accept && sel_last) state_q <= GAP;
        end
        GAP: begin
          // The tlast beat is the last entry in the skid buffer. Once it
          // handshakes, the buffer is empty at this same edge.
          if (m_hs_last) begin
            grant_q <= '0;
            if (IFG_CYC == 0) begin
              state_q <= IDLE;
            end else begin
              tlast_out_q <= 1'b1;
              gap_cnt_q   <= 4'(IFG_CYC);
            end
          end else if (tlast_out_q && skid_empty) begin
            if (gap_cnt_q <= 4'd1) begin
              state_q     <= IDLE;
              tlast_out_q <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign o_frame_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_ethernet_tx_frame_arbiter.sv
module tb_ethernet_tx_frame_arbiter;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    beat_t      b;
    int         ch;
    int         cyc;
    logic [2:0] grant;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]   s_tvalid [3];
  logic [2:0]   s_tready [3];
  logic [191:0] s_tdata  [3];
  logic [23:0]  s_tkeep  [3];
  logic [2:0]   s_tlast  [3];
  logic         m_tvalid [3];
  logic         m_tready [3];
  logic [63:0]  m_tdata  [3];
  logic [7:0]   m_tkeep  [3];
  logic         m_tlast  [3];
  logic [2:0]   grant    [3];
  logic         busy     [3];
  logic [47:0]  cnt_bus  [3];

  always #5 clk = ~clk;

  // DUT 0: round-robin, IFG 1. DUT 1: fixed priority, IFG 1. DUT 2: round-robin, IFG 0, 4-bit counters.
  for (genvar d = 0; d < 3; d++) begin : g
    localparam int CW = (d == 2) ? 4 : 16;
    logic [3*CW-1:0] cnt_l;
    ethernet_tx_frame_arbiter #(
      .NUM_CH(3), .DATA_W(64), .ARB_MODE((d == 1) ? 1 : 0),
      .IFG_CYC((d == 2) ? 0 : 1), .CNT_W(CW)
    ) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .s_axis_tvalid(s_tvalid[d]), .s_axis_tready(s_tready[d]),
      .s_axis_tdata(s_tdata[d]), .s_axis_tkeep(s_tkeep[d]), .s_axis_tlast(s_tlast[d]),
      .m_axis_tvalid(m_tvalid[d]), .m_axis_tready(m_tready[d]),
      .m_axis_tdata(m_tdata[d]), .m_axis_tkeep(m_tkeep[d]), .m_axis_tlast(m_tlast[d]),
      .o_grant(grant[d]), .o_busy(busy[d]), .o_frame_cnt(cnt_l)
    );
    assign cnt_bus[d] = 48'(cnt_l);
  end

  beat_t srcq [3][$];
  int    flen [3][$];
  obs_t  obs[$];
  obs_t  expq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    stall_viol = 0;
  int    last_busy_cyc = 0;
  int    cur = 0;
  int    tready_mode = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_b;

  function automatic int get_cnt(input int d, input int c);
    int cw;
    cw = (d == 2) ? 4 : 16;
    return int'((cnt_bus[d] >> (c * cw)) & ((48'd1 << cw) - 48'd1));
  endfunction

  task automatic drive();
    for (int d = 0; d < 3; d++) begin
      s_tvalid[d] = '0; s_tdata[d] = '0; s_tkeep[d] = '0; s_tlast[d] = '0; m_tready[d] = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      if (srcq[c].size() > 0) begin
        s_tvalid[cur][c]         = 1'b1;
        s_tdata[cur][c*64 +: 64] = srcq[c][0].data;
        s_tkeep[cur][c*8 +: 8]   = srcq[c][0].keep;
        s_tlast[cur][c]          = srcq[c][0].last;
      end
    end
    case (tready_mode)
      0:       m_tready[cur] = 1'b1;
      1:       m_tready[cur] = (cyc % 2 == 0);
      default: m_tready[cur] = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic sample();
    obs_t o;
    for (int c = 0; c < 3; c++)
      if (s_tvalid[cur][c] && s_tready[cur][c]) void'(srcq[c].pop_front());
    if (prev_stall && (m_tvalid[cur] !== 1'b1 || m_tdata[cur] !== prev_b.data ||
                       m_tkeep[cur] !== prev_b.keep || m_tlast[cur] !== prev_b.last))
      stall_viol++;
    prev_stall  = m_tvalid[cur] && !m_tready[cur];
    prev_b.data = m_tdata[cur];
    prev_b.keep = m_tkeep[cur];
    prev_b.last = m_tlast[cur];
    if (busy[cur]) last_busy_cyc = cyc;
    if (m_tvalid[cur] && m_tready[cur]) begin
      o.b = prev_b; o.ch = -1; o.cyc = cyc; o.grant = grant[cur];
      obs.push_back(o);
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk); #1; drive();
    @(negedge clk); sample();
  endtask

  function automatic bit all_empty();
    return (srcq[0].size() + srcq[1].size() + srcq[2].size()) == 0;
  endfunction

  task automatic run(input int budget, output bit timed_out);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(all_empty() && !busy[cur] && !m_tvalid[cur]) && n < budget);
    timed_out = !(all_empty() && !busy[cur] && !m_tvalid[cur]);
  endtask

  task automatic add_frame(input int ch, input int len, input logic [7:0] last_keep, input logic [63:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = (base != 0) ? base + 64'(i) : {$urandom, $urandom};
      b.keep = (i == len - 1) ? last_keep : 8'hFF;
      b.last = (i == len - 1);
      srcq[ch].push_back(b);
    end
    flen[ch].push_back(len);
  endtask

  // Reference: every channel with frames queued is requesting. At each decision the
  // winner is the first requester scanning from the start point (last winner + 1 for
  // round-robin, channel 0 for fixed). The winner's whole frame goes out before the next decision.
  task automatic build_expected(input int mode);
    beat_t mq [3][$];
    int    ml [3][$];
    int    ptr, ch, c2, n;
    obs_t  e;
    expq.delete();
    ptr = 0;
    for (int c = 0; c < 3; c++) begin mq[c] = srcq[c]; ml[c] = flen[c]; end
    while (ml[0].size() + ml[1].size() + ml[2].size() > 0) begin
      ch = -1;
      for (int k = 0; k < 3; k++) begin
        c2 = (mode == 1) ? k : (ptr + k) % 3;
        if (ch < 0 && ml[c2].size() > 0) ch = c2;
      end
      ptr = (ch + 1) % 3;
      n = ml[ch].pop_front();
      for (int i = 0; i < n; i++) begin
        e.b = mq[ch].pop_front(); e.ch = ch; e.cyc = 0; e.grant = '0;
        expq.push_back(e);
      end
    end
  endtask

  function automatic int first_bad();
    int n;
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++)
      if (obs[i].b !== expq[i].b || obs[i].grant !== (3'b001 << expq[i].ch)) return i;
    if (obs.size() != expq.size()) return n;
    return -1;
  endfunction

  function automatic int min_gap();
    int gmin;
    gmin = 1000;
    for (int i = 0; i + 1 < obs.size(); i++)
      if (obs[i].b.last && (obs[i+1].cyc - obs[i].cyc - 1) < gmin) gmin = obs[i+1].cyc - obs[i].cyc - 1;
    return gmin;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin srcq[c].delete(); flen[c].delete(); end
    obs.delete(); expq.delete();
    stall_viol = 0; prev_stall = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cur = 0; tready_mode = 0;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin srcq[c].delete(); flen[c].delete(); end
    drive();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({m_tvalid[d], m_tlast[d], m_tdata[d], m_tkeep[d], grant[d], busy[d], s_tready[d], cnt_bus[d]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d got mv=%b data=%h grant=%b busy=%b cnt=%h required all zero",
                 d, m_tvalid[d], m_tdata[d], grant[d], busy[d], cnt_bus[d]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (busy[0] !== 1'b0 || grant[0] !== 3'b000 || m_tvalid[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b grant=%b mv=%b required 0/000/0", busy[0], grant[0], m_tvalid[0]);
    end
  endtask

  task automatic test_single_frame();
    bit to; int bad;
    cur = 0; tready_mode = 0; do_reset();
    add_frame(1, 3, 8'hFF, 64'd0);
    build_expected(0);
    run(500, to);
    bad = first_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("FAIL single_stream timeout=%0d first_bad=%0d beats=%0d required first_bad=-1 beats=%0d", to, bad, obs.size(), expq.size());
    end
    checks++;
    if (obs.size() != 3 || obs[obs.size()-1].cyc - obs[0].cyc != 2) begin
      failures++;
      $display("FAIL single_contiguous beats=%0d required 3 contiguous beats", obs.size());
    end
    checks++;
    if (get_cnt(0, 1) != 1 || get_cnt(0, 0) != 0 || get_cnt(0, 2) != 0) begin
      failures++;
      $display("FAIL single_counters got %0d/%0d/%0d required 0/1/0", get_cnt(0, 0), get_cnt(0, 1), get_cnt(0, 2));
    end
    checks++;
    if (obs.size() > 0 && last_busy_cyc - obs[obs.size()-1].cyc != 1) begin
      failures++;
      $display("FAIL single_gap_len got %0d required 1", last_busy_cyc - obs[obs.size()-1].cyc);
    end
    checks++;
    if (grant[0] !== 3'b000 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_end_idle got grant=%b busy=%b required 000/0", grant[0], busy[0]);
    end
  endtask

  task automatic test_round_robin();
    bit to; int bad;
    cur = 0; tready_mode = 0; do_reset();
    for (int f = 0; f < 2; f++) for (int c = 0; c < 3; c++) add_frame(c, 2, 8'hFF, 64'd0);
    build_expected(0);
    run(1000, to);
    bad = first_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("FAIL rr_stream timeout=%0d first_bad=%0d beats=%0d required first_bad=-1 beats=%0d", to, bad, obs.size(), expq.size());
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (get_cnt(0, c) != 2) begin
        failures++;
        $display("FAIL rr_count ch=%0d got %0d required 2", c, get_cnt(0, c));
      end
    end
    checks++;
    if (min_gap() < 1) begin
      failures++;
      $display("FAIL rr_ifg got min gap %0d required >=1", min_gap());
    end
  endtask

  task automatic test_fixed_priority();
    bit to; int bad;
    cur = 1; tready_mode = 0; do_reset();
    for (int f = 0; f < 4; f++) add_frame(0, 2, 8'hFF, 64'd0);
    for (int f = 0; f < 2; f++) add_frame(2, 3, 8'hFF, 64'd0);
    build_expected(1);
    run(1000, to);
    bad = first_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("FAIL fixed_stream timeout=%0d first_bad=%0d beats=%0d required first_bad=-1 beats=%0d", to, bad, obs.size(), expq.size());
    end
    checks++;
    if (get_cnt(1, 0) != 4 || get_cnt(1, 1) != 0 || get_cnt(1, 2) != 2) begin
      failures++;
      $display("FAIL fixed_counters got %0d/%0d/%0d required 4/0/2", get_cnt(1, 0), get_cnt(1, 1), get_cnt(1, 2));
    end
  endtask

  task automatic test_backpressure();
    bit to; int bad;
    cur = 0; tready_mode = 1; do_reset();
    add_frame(0, 4, 8'hFF, 64'hA0);
    add_frame(1, 2, 8'h3F, 64'd0);
    build_expected(0);
    run(1000, to);
    bad = first_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("FAIL bp_stream timeout=%0d first_bad=%0d beats=%0d required first_bad=-1 beats=%0d", to, bad, obs.size(), expq.size());
    end
    checks++;
    if (stall_viol != 0) begin
      failures++;
      $display("FAIL bp_stable got %0d unstable stalled cycles required 0", stall_viol);
    end
  endtask

  task automatic test_random();
    bit to; int bad; int nf;
    cur = 0; tready_mode = 2; do_reset();
    nf = 10 + int'($urandom_range(0, 6));
    for (int f = 0; f < nf; f++)
      add_frame(int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 8'($urandom_range(0, 255)), 64'd0);
    build_expected(0);
    run(3000, to);
    bad = first_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("FAIL rand_stream timeout=%0d first_bad=%0d beats=%0d required first_bad=-1 beats=%0d", to, bad, obs.size(), expq.size());
    end
    checks++;
    if (stall_viol != 0) begin
      failures++;
      $display("FAIL rand_stable got %0d unstable stalled cycles required 0", stall_viol);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (get_cnt(0, c) != flen[c].size()) begin
        failures++;
        $display("FAIL rand_count ch=%0d got %0d required %0d", c, get_cnt(0, c), flen[c].size());
      end
    end
    checks++;
    if (min_gap() < 1) begin
      failures++;
      $display("FAIL rand_ifg got min gap %0d required >=1", min_gap());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to; int bad;
    cur = 0; tready_mode = 0; do_reset();
    add_frame(0, 8, 8'hFF, 64'd0);
    repeat (4) step();
    checks++;
    if (obs.size() != 2) begin
      failures++;
      $display("FAIL midrst_latency got %0d beats out required 2", obs.size());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_tvalid[0], m_tlast[0], m_tdata[0], m_tkeep[0], grant[0], busy[0], s_tready[0], cnt_bus[0]} !== '0) begin
      failures++;
      $display("FAIL midrst_async got mv=%b data=%h grant=%b busy=%b tready=%b required all zero",
               m_tvalid[0], m_tdata[0], grant[0], busy[0], s_tready[0]);
    end
    for (int c = 0; c < 3; c++) begin srcq[c].delete(); flen[c].delete(); end
    obs.delete(); prev_stall = 1'b0; stall_viol = 0;
    drive();
    @(negedge clk); rst_n = 1'b1;
    add_frame(2, 3, 8'hFF, 64'd0);
    build_expected(0);
    run(500, to);
    bad = first_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("FAIL midrst_stream timeout=%0d first_bad=%0d beats=%0d required first_bad=-1 beats=%0d", to, bad, obs.size(), expq.size());
    end
    checks++;
    if (get_cnt(0, 0) != 0 || get_cnt(0, 2) != 1) begin
      failures++;
      $display("FAIL midrst_counters got ch0=%0d ch2=%0d required 0/1", get_cnt(0, 0), get_cnt(0, 2));
    end
  endtask

  task automatic test_counter_wrap();
    bit to; int bad;
    cur = 2; tready_mode = 0; do_reset();
    for (int f = 0; f < 17; f++)
      add_frame(0, 1, (f == 16) ? 8'h0F : ((f == 5) ? 8'h00 : 8'hFF), 64'd0);
    build_expected(0);
    run(2000, to);
    bad = first_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("FAIL wrap_stream timeout=%0d first_bad=%0d beats=%0d required first_bad=-1 beats=%0d", to, bad, obs.size(), expq.size());
    end
    checks++;
    if (get_cnt(2, 0) != 1) begin
      failures++;
      $display("FAIL wrap_count got %0d required 1", get_cnt(2, 0));
    end
    checks++;
    if (obs.size() == 0 || obs[obs.size()-1].b.keep !== 8'h0F) begin
      failures++;
      $display("FAIL wrap_last_keep beats=%0d required last keep 0f", obs.size());
    end
    checks++;
    if (obs.size() > 0 && last_busy_cyc - obs[obs.size()-1].cyc != 0) begin
      failures++;
      $display("FAIL wrap_gap_len got %0d required 0", last_busy_cyc - obs[obs.size()-1].cyc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    prev_b = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_random();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
